// File: rtl/slave_pkg.sv
// Shared types and constants for the handshaked memory slave.
package slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/slave_mem_array.sv
// Word storage: synchronous byte-strobed write port, combinational read port.
module slave_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [IDX_WIDTH-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic [IDX_WIDTH-1:0]      raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte-lane write; lanes with a cleared strobe keep their old contents.
  // NOTE: storage has no reset branch so it maps onto plain RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/slave_mem_hs.sv
// Word-addressed memory slave with valid/ready request and response channels,
// programmable latency and out-of-range error reporting. One transaction in flight.
module slave_mem_hs
  import slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_WIDTH = $clog2(LATENCY + 1);
  localparam logic [ADDR_WIDTH:0]  DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(LATENCY - 1);

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic                  accept, enter_resp;
  logic                  req_in_range;
  logic                  lat_wen, lat_err;
  logic [IDX_WIDTH-1:0]  lat_idx;
  logic                  cur_wen, cur_err;
  logic [IDX_WIDTH-1:0]  cur_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;

  // Unsigned compare over the full address width (extra bit holds MEM_DEPTH itself).
  assign req_in_range = ({1'b0, req_addr} < DEPTH_EXT);
  assign req_ready    = (state == IDLE);
  assign rsp_valid    = (state == RESP);
  assign mem_we       = accept && req_wen && req_in_range;

  // With LATENCY=1 the RESP entry coincides with the accept edge, so the live
  // request drives the response source; otherwise the latched copy does.
  assign cur_wen = (state == IDLE) ? req_wen       : lat_wen;
  assign cur_err = (state == IDLE) ? !req_in_range : lat_err;
  assign cur_idx = (state == IDLE) ? req_addr[IDX_WIDTH-1:0] : lat_idx;

  slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (req_addr[IDX_WIDTH-1:0]),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .raddr (cur_idx),
    .rdata (mem_rdata)
  );

  // State and latency counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP until taken.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture the request attributes needed once the request channel moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_wen <= 1'b0;
      lat_err <= 1'b0;
      lat_idx <= '0;
    end else if (accept) begin
      lat_wen <= req_wen;
      lat_err <= !req_in_range;
      lat_idx <= req_addr[IDX_WIDTH-1:0];
    end
  end

  // Response registers: loaded entering RESP, held under backpressure, cleared on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= RSP_OK;
    end else if (enter_resp) begin
      rsp_err   <= cur_err ? RSP_ERR : RSP_OK;
      rsp_rdata <= (cur_wen || cur_err) ? '0 : mem_rdata;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= RSP_OK;
    end
  end

endmodule

// File: tb/tb_slave_mem_hs.sv
// Self-checking bench: transaction-level reference model checked every cycle,
// directed transactions with literal expectations, then randomized traffic.
module tb_slave_mem_hs;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int LAT4  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_valid4 = 1'b0;
  logic          req_wen = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready, rsp_valid, rsp_err;
  logic          req_ready4, rsp_valid4, rsp_err4;
  logic [DW-1:0] rsp_rdata, rsp_rdata4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  slave_mem_hs #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MEM_DEPTH (DEPTH), .LATENCY (LAT)
  ) u_dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_wen (req_wen),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata), .rsp_err (rsp_err)
  );

  slave_mem_hs #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MEM_DEPTH (DEPTH), .LATENCY (LAT4)
  ) u_dut4 (
    .clk (clk), .rst (rst),
    .req_valid (req_valid4), .req_ready (req_ready4), .req_wen (req_wen),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid4), .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata4), .rsp_err (rsp_err4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model (LATENCY=2 instance) ----------------
  logic [DW-1:0] mem_m   [DEPTH];
  logic [3:0]    known_m [DEPTH];
  bit            busy_m    = 1'b0;
  longint        edge_n    = 0;
  longint        resp_edge = 0;
  logic [DW-1:0] exp_data  = '0;
  logic [DW-1:0] exp_mask  = '1;
  logic          exp_err   = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) known_m[i] = 4'h0;

  // Transaction view: accepted when idle, response visible LAT edges later,
  // retired on the first edge it is visible with rsp_ready high.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_m = 1'b0;
    end else begin
      if (!busy_m) begin
        if (req_valid) begin
          busy_m    = 1'b1;
          resp_edge = edge_n + 1 + LAT;
          exp_mask  = '1;
          exp_data  = '0;
          if (int'(req_addr) >= DEPTH) begin
            exp_err = 1'b1;
          end else begin
            exp_err = 1'b0;
            if (req_wen) begin
              for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                  mem_m[req_addr[9:0]][8*b +: 8] = req_wdata[8*b +: 8];
                  known_m[req_addr[9:0]][b]      = 1'b1;
                end
              end
            end else begin
              exp_data = mem_m[req_addr[9:0]];
              for (int b = 0; b < 4; b++)
                exp_mask[8*b +: 8] = known_m[req_addr[9:0]][b] ? 8'hFF : 8'h00;
            end
          end
        end
      end else if (edge_n >= resp_edge && rsp_ready) begin
        busy_m = 1'b0;
      end
      edge_n++;
    end
  end

  // Compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    bit vis;
    vis = busy_m && (edge_n >= resp_edge);
    check("req_ready", 32'(req_ready), 32'(!busy_m));
    check("rsp_valid", 32'(rsp_valid), 32'(vis));
    check("rsp_err",   32'(rsp_err),   vis ? 32'(exp_err) : 32'h0);
    check("rsp_rdata", rsp_rdata & (vis ? exp_mask : '1),
          vis ? (exp_data & exp_mask) : 32'h0);
  end

  // ---------------- directed transaction on the LATENCY=2 instance ----------------
  task automatic do_txn(input string tag, input logic wen, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [3:0] strb,
                        input int hold, input bit keep_valid,
                        input logic [DW-1:0] exp_rd, input logic exp_e);
    int w;
    int lat;
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_wdata = wdata; req_wstrb = strb; rsp_ready = 1'b0;
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    check({tag, "_accept"}, 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    if (!keep_valid) req_valid = 1'b0;
    check({tag, "_busy"}, 32'(req_ready), 32'h0);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'h1);
      check({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_e));
      check({tag, "_hold_ready"}, 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_done_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_done_err"}, 32'(rsp_err), 32'h0);
  endtask

  initial begin
    int lat;
    int r;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    do_txn("wr5_full", 1'b1, 16'd5, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    do_txn("rd5_full", 1'b0, 16'd5, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    do_txn("wr5_part", 1'b1, 16'd5, 32'h000000AA, 4'h1, 0, 1'b0, 32'h0, 1'b0);
    do_txn("rd5_part", 1'b0, 16'd5, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEAA, 1'b0);
    do_txn("wr5_nostrb", 1'b1, 16'd5, 32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h0, 1'b0);
    do_txn("rd5_nostrb", 1'b0, 16'd5, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEAA, 1'b0);
    do_txn("wr0", 1'b1, 16'd0, 32'h11111111, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    do_txn("wr1024", 1'b1, 16'd1024, 32'h12345678, 4'hF, 0, 1'b0, 32'h0, 1'b1);
    do_txn("rd1024", 1'b0, 16'd1024, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b1);
    do_txn("rd0", 1'b0, 16'd0, 32'h0, 4'h0, 0, 1'b0, 32'h11111111, 1'b0);
    do_txn("rd_ffff", 1'b0, 16'hFFFF, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b1);

    // Backpressure with a new request waiting behind the response.
    do_txn("bp_rd5", 1'b0, 16'd5, 32'h0, 4'h0, 5, 1'b1, 32'hDEADBEAA, 1'b0);
    check("bp_ready_after", 32'(req_ready), 32'h1);
    do_txn("bp_next", 1'b0, 16'd5, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEAA, 1'b0);

    // Reset while the LATENCY=4 instance waits on a committed write.
    req_wen = 1'b1; req_addr = 16'd7; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    req_valid4 = 1'b1;
    check("l4_ready", 32'(req_ready4), 32'h1);
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    check("l4_busy", 32'(req_ready4), 32'h0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("rst_l4_req_ready", 32'(req_ready4), 32'h1);
    check("rst_l4_rsp_valid", 32'(rsp_valid4), 32'h0);
    check("rst_l4_rsp_rdata", rsp_rdata4, 32'h0);
    check("rst_l4_rsp_err", 32'(rsp_err4), 32'h0);
    check("rst_l2_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #3 rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      check("l4_dropped_rsp", 32'(rsp_valid4), 32'h0);
    end
    req_wen = 1'b0; req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    lat = 0;
    while (!rsp_valid4 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("l4_latency", 32'(lat), 32'(LAT4));
    check("l4_rd7_rdata", rsp_rdata4, 32'hCAFEF00D);
    check("l4_rd7_err", 32'(rsp_err4), 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("l4_done_valid", 32'(rsp_valid4), 32'h0);
    check("l4_done_ready", 32'(req_ready4), 32'h1);

    // Randomized traffic on the LATENCY=2 instance, checked by the model.
    repeat (600) begin
      r = $urandom_range(0, 9);
      req_valid = 1'($urandom_range(0, 1));
      req_wen   = 1'($urandom_range(0, 1));
      req_addr  = (r < 7) ? 16'($urandom_range(0, 15)) :
                  (r == 7) ? 16'd1023 : (r == 8) ? 16'd1024 : 16'hFFFF;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    check("drain_idle", 32'(req_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
